// File: rtl/periph_req_fifo_pe.sv
// rtl/periph_req_fifo_pe.sv - elastic request FIFO with registered response return path
module periph_req_fifo_pe #(
    parameter int ID_WIDTH   = 20,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int DEPTH      = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    // upstream (arbiter side)
    input  logic                         data_req_i,
    input  logic [ADDR_WIDTH-1:0]        data_add_i,
    input  logic                         data_wen_i,
    input  logic [DATA_WIDTH-1:0]        data_wdata_i,
    input  logic [BE_WIDTH-1:0]          data_be_i,
    input  logic [ID_WIDTH-1:0]          data_ID_i,
    output logic                         data_gnt_o,
    // downstream (slave side)
    output logic                         data_req_o,
    output logic [ADDR_WIDTH-1:0]        data_add_o,
    output logic                         data_wen_o,
    output logic [DATA_WIDTH-1:0]        data_wdata_o,
    output logic [BE_WIDTH-1:0]          data_be_o,
    output logic [ID_WIDTH-1:0]          data_ID_o,
    input  logic                         data_gnt_i,
    // response return path
    input  logic                         data_r_valid_i,
    input  logic [DATA_WIDTH-1:0]        data_r_rdata_i,
    input  logic [ID_WIDTH-1:0]          data_r_ID_i,
    output logic                         data_r_valid_o,
    output logic [DATA_WIDTH-1:0]        data_r_rdata_o,
    output logic [ID_WIDTH-1:0]          data_r_ID_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = ADDR_WIDTH + 1 + DATA_WIDTH + BE_WIDTH + ID_WIDTH;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head;

    // Grant and request come only from the occupancy register, so neither
    // side sees a combinational path from the other side's handshake.
    assign data_gnt_o = (count != CNT_W'(DEPTH));
    assign data_req_o = (count != '0);
    assign push       = data_req_i & data_gnt_o;
    assign pop        = data_req_o & data_gnt_i;
    assign count_o    = count;

    assign head = mem[rd_ptr];
    assign {data_add_o, data_wen_o, data_wdata_o, data_be_o, data_ID_o} = head;

    // Entry storage; cleared on reset so idle payload outputs read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= {data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i};
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy: simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Response path is a plain one-cycle register stage with no backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r_valid_o <= 1'b0;
            data_r_rdata_o <= '0;
            data_r_ID_o    <= '0;
        end else begin
            data_r_valid_o <= data_r_valid_i;
            data_r_rdata_o <= data_r_rdata_i;
            data_r_ID_o    <= data_r_ID_i;
        end
    end

endmodule

// File: tb/tb_periph_req_fifo_pe.sv
// tb/tb_periph_req_fifo_pe.sv - scoreboard testbench for periph_req_fifo_pe
module tb_periph_req_fifo_pe;

    localparam int IDW   = 20;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BEW   = DW / 8;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [AW-1:0]  add;
        logic           wen;
        logic [DW-1:0]  wdata;
        logic [BEW-1:0] be;
        logic [IDW-1:0] id;
    } ent_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           data_req_i;
    logic [AW-1:0]  data_add_i;
    logic           data_wen_i;
    logic [DW-1:0]  data_wdata_i;
    logic [BEW-1:0] data_be_i;
    logic [IDW-1:0] data_ID_i;
    logic           data_gnt_o;
    logic           data_req_o;
    logic [AW-1:0]  data_add_o;
    logic           data_wen_o;
    logic [DW-1:0]  data_wdata_o;
    logic [BEW-1:0] data_be_o;
    logic [IDW-1:0] data_ID_o;
    logic           data_gnt_i;
    logic           data_r_valid_i;
    logic [DW-1:0]  data_r_rdata_i;
    logic [IDW-1:0] data_r_ID_i;
    logic           data_r_valid_o;
    logic [DW-1:0]  data_r_rdata_o;
    logic [IDW-1:0] data_r_ID_o;
    logic [CW-1:0]  count_o;

    int   total = 0;
    int   bad   = 0;
    ent_t exp_q[$];
    int   mdl_cnt = 0;
    logic rand_gnt = 1'b0;
    logic           prev_v = 1'b0;
    logic [DW-1:0]  prev_d = '0;
    logic [IDW-1:0] prev_id = '0;

    periph_req_fifo_pe #(
        .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BEW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
        .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_ID_i(data_ID_i),
        .data_gnt_o(data_gnt_o),
        .data_req_o(data_req_o), .data_add_o(data_add_o), .data_wen_o(data_wen_o),
        .data_wdata_o(data_wdata_o), .data_be_o(data_be_o), .data_ID_o(data_ID_o),
        .data_gnt_i(data_gnt_i),
        .data_r_valid_i(data_r_valid_i), .data_r_rdata_i(data_r_rdata_i), .data_r_ID_i(data_r_ID_i),
        .data_r_valid_o(data_r_valid_o), .data_r_rdata_o(data_r_rdata_o), .data_r_ID_o(data_r_ID_o),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference occupancy model, acceptance tracking and response-path check.
    always @(negedge clk) begin
        if (!rst_n) begin
            mdl_cnt = 0;
            exp_q.delete();
            prev_v  = 1'b0;
            prev_d  = '0;
            prev_id = '0;
        end else begin
            logic mpush, mpop;
            ent_t e;
            check("gnt_o", data_gnt_o, mdl_cnt != DEPTH);
            check("req_o", data_req_o, mdl_cnt != 0);
            check("count_o", count_o, mdl_cnt);
            check("r_valid_o", data_r_valid_o, prev_v);
            check("r_rdata_o", data_r_rdata_o, prev_d);
            check("r_ID_o", data_r_ID_o, prev_id);
            prev_v  = data_r_valid_i;
            prev_d  = data_r_rdata_i;
            prev_id = data_r_ID_i;
            mpush = data_req_i && (mdl_cnt != DEPTH);
            mpop  = (mdl_cnt != 0) && data_gnt_i;
            if (mpush) begin
                e = '{add: data_add_i, wen: data_wen_i, wdata: data_wdata_i, be: data_be_i, id: data_ID_i};
                exp_q.push_back(e);
            end
            mdl_cnt = mdl_cnt + int'(mpush) - int'(mpop);
        end
    end

    // Monitor: head payload must match the oldest outstanding request, stalled or not.
    always @(negedge clk) begin
        if (rst_n && data_req_o) begin
            check("head_avail", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                ent_t got;
                got = '{add: data_add_o, wen: data_wen_o, wdata: data_wdata_o, be: data_be_o, id: data_ID_o};
                check("head_payload", got, exp_q[0]);
                if (data_gnt_i) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_gnt) data_gnt_i = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input ent_t e);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        data_req_i   = 1'b1;
        data_add_i   = e.add;
        data_wen_i   = e.wen;
        data_wdata_i = e.wdata;
        data_be_i    = e.be;
        data_ID_i    = e.id;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = data_gnt_o;
            tick();
            n++;
        end
        check("accept_in_budget", acc, 1'b1);
        data_req_i = 1'b0;
    endtask

    initial begin
        ent_t e;
        rst_n = 1'b0;
        data_req_i = 1'b0; data_add_i = '0; data_wen_i = 1'b0; data_wdata_i = '0;
        data_be_i = '0; data_ID_i = '0; data_gnt_i = 1'b1;
        data_r_valid_i = 1'b0; data_r_rdata_i = '0; data_r_ID_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt_o", data_gnt_o, 1'b1);
        check("rst_req_o", data_req_o, 1'b0);
        check("rst_count_o", count_o, 0);
        check("rst_add_o", data_add_o, 0);
        check("rst_r_valid_o", data_r_valid_o, 1'b0);
        rst_n = 1'b1;
        tick();

        // single write, slave always granting
        data_gnt_i = 1'b1;
        send('{add: 32'h100, wen: 1'b0, wdata: 32'hDEADBEEF, be: 4'hF, id: 20'h3});
        repeat (3) tick();

        // fill to full with slave stalled, then release
        data_gnt_i = 1'b0;
        fork
            begin
                send('{add: 32'h1000, wen: 1'b1, wdata: 32'h11111111, be: 4'h1, id: 20'h1});
                send('{add: 32'h2000, wen: 1'b0, wdata: 32'h22222222, be: 4'h3, id: 20'h2});
                send('{add: 32'h3000, wen: 1'b1, wdata: 32'h33333333, be: 4'h7, id: 20'h3});
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                data_gnt_i = 1'b1;
            end
        join
        repeat (4) tick();

        // streaming with simultaneous push/pop
        data_gnt_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send('{add: 32'h4000 + 32'(i * 4), wen: i[0], wdata: 32'hA5A50000 + 32'(i),
                   be: 4'(i + 1), id: 20'h10 + 20'(i)});
        end
        repeat (3) tick();

        // random slave stall with random payloads
        rand_gnt = 1'b1;
        for (int i = 0; i < 100; i++) begin
            e.add   = $urandom;
            e.wen   = 1'($urandom_range(0, 1));
            e.wdata = $urandom;
            e.be    = 4'($urandom_range(0, 15));
            e.id    = 20'($urandom);
            send(e);
        end
        rand_gnt = 1'b0;
        data_gnt_i = 1'b1;
        repeat (4) tick();

        // reset mid-operation with two entries buffered
        data_gnt_i = 1'b0;
        data_r_valid_i = 1'b1; data_r_rdata_i = 32'h12345678; data_r_ID_i = 20'h9;
        send('{add: 32'hBAD0, wen: 1'b0, wdata: 32'hBAD00001, be: 4'hF, id: 20'hB1});
        send('{add: 32'hBAD4, wen: 1'b0, wdata: 32'hBAD00002, be: 4'hF, id: 20'hB2});
        check("pre_rst_count_o", count_o, 2);
        check("pre_rst_r_valid_o", data_r_valid_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_req_o", data_req_o, 1'b0);
        check("async_rst_count_o", count_o, 0);
        check("async_rst_gnt_o", data_gnt_o, 1'b1);
        check("async_rst_r_valid_o", data_r_valid_o, 1'b0);
        check("async_rst_ID_o", data_ID_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        data_r_valid_i = 1'b0; data_r_rdata_i = '0; data_r_ID_i = '0;
        data_gnt_i = 1'b1;
        repeat (3) tick();

        // response path
        data_r_valid_i = 1'b1; data_r_rdata_i = 32'hCAFEF00D; data_r_ID_i = 20'h5;
        tick();
        check("resp_valid", data_r_valid_o, 1'b1);
        check("resp_rdata", data_r_rdata_o, 32'hCAFEF00D);
        check("resp_ID", data_r_ID_o, 20'h5);
        data_r_valid_i = 1'b0; data_r_rdata_i = '0; data_r_ID_i = '0;
        tick();
        check("resp_valid_drop", data_r_valid_o, 1'b0);

        repeat (4) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
